softmax_seq_ctrl: RTL

Sequencer for the 256-class softmax core at the back end of the classifier. It buffers one logit vector arriving from the final FC layer and drives the core's `en`/`x_in` for both passes (max/sum, then divide). It collects the core's out-of-order quotient stream into a result RAM, tracks the top-1 class, and exposes results to the host-side readout.

---
 rtl/softmax_seq_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/softmax_seq_ctrl.sv
// rtl/softmax_seq_ctrl.sv - softmax core sequencer: logit buffer, two-pass drive, quotient capture, argmax
module softmax_seq_ctrl #(
  parameter int WL      = 8,
  parameter int VLEN    = 256,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          s_valid,
  input  logic [WL-1:0] s_data,
  output logic          s_ready,
  output logic          sm_en,
  output logic [WL-1:0] sm_x,
  input  logic [WL-1:0] sm_q,
  input  logic [7:0]    sm_idx,
  input  logic          sm_out_en,
  input  logic [7:0]    rd_addr,
  output logic [WL-1:0] rd_data,
  output logic          busy,
  output logic          done,
  input  logic          ack,
  output logic [7:0]    top_idx,
  output logic [WL-1:0] top_val,
  output logic          err_timeout
);
  localparam int CW = $clog2(VLEN + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PRIME, S_RUN1, S_RUN2, S_DRAIN, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    top_idx_q, top_idx_d;
  logic [WL-1:0] top_val_q, top_val_d;
  logic          err_q, err_d;
  logic          sm_en_q, sm_en_d;
  logic [WL-1:0] sm_x_q, sm_x_d;
  logic [WL-1:0] rd_data_q;

  logic [WL-1:0] lbuf    [VLEN];
  logic [WL-1:0] res_ram [VLEN];

  logic accept, capture, last_idx;

  assign accept   = (state_q == S_LOAD) && s_valid;
  assign capture  = sm_out_en && ((state_q == S_RUN2) || (state_q == S_DRAIN));
  assign last_idx = (idx_q == 8'(VLEN - 1));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;
    top_idx_d = top_idx_q;
    top_val_d = top_val_q;
    err_d     = err_q;
    sm_en_d   = 1'b0;
    sm_x_d    = '0;

    // Ties on value go to the lower index; the first strobe of a job always wins.
    if (capture) begin
      if (cnt_q != CW'(VLEN)) cnt_d = cnt_q + CW'(1);
      if ((cnt_q == '0) || (sm_q > top_val_q) ||
          ((sm_q == top_val_q) && (sm_idx < top_idx_q))) begin
        top_idx_d = sm_idx;
        top_val_d = sm_q;
      end
    end

    case (state_q)
      S_IDLE: if (start) begin
        state_d   = S_LOAD;
        idx_d     = '0;
        tmo_d     = '0;
        cnt_d     = '0;
        top_idx_d = '0;
        top_val_d = '0;
        err_d     = 1'b0;
      end
      S_LOAD: if (accept) begin
        idx_d = idx_q + 8'd1;
        if (last_idx) state_d = S_PRIME;
      end
      S_PRIME: state_d = S_RUN1;
      S_RUN1: begin
        idx_d = idx_q + 8'd1;
        if (last_idx) state_d = S_RUN2;
      end
      S_RUN2: begin
        idx_d = idx_q + 8'd1;
        if (last_idx) begin
          state_d = S_DRAIN;
          tmo_d   = '0;
        end
      end
      S_DRAIN: begin
        tmo_d = tmo_q + TW'(1);
        if (cnt_d == CW'(VLEN)) begin
          state_d = S_DONE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_DONE: if (ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Core strobes are registered, so they are derived from the next state.
    if (state_d == S_PRIME) begin
      sm_en_d = 1'b1;
    end else if ((state_d == S_RUN1) || (state_d == S_RUN2)) begin
      sm_en_d = 1'b1;
      sm_x_d  = lbuf[idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      tmo_q     <= '0;
      cnt_q     <= '0;
      top_idx_q <= '0;
      top_val_q <= '0;
      err_q     <= 1'b0;
      sm_en_q   <= 1'b0;
      sm_x_q    <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
      top_idx_q <= top_idx_d;
      top_val_q <= top_val_d;
      err_q     <= err_d;
      sm_en_q   <= sm_en_d;
      sm_x_q    <= sm_x_d;
      rd_data_q <= res_ram[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (accept)  lbuf[idx_q]     <= s_data;
    if (capture) res_ram[sm_idx] <= sm_q;
  end

  assign s_ready     = (state_q == S_LOAD);
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign sm_en       = sm_en_q;
  assign sm_x        = sm_x_q;
  assign rd_data     = rd_data_q;
  assign top_idx     = top_idx_q;
  assign top_val     = top_val_q;
  assign err_timeout = err_q;
endmodule
